muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer_if.sv | 26 ++
 rtl/muldiv_sequencer.sv | 173 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle for the sequential signed multiply/divide unit.
// The requester drives start/Op/A/B; the unit returns status and the HI/LO result.
interface muldiv_sequencer_if;
  localparam int unsigned W = 32;
  localparam int unsigned OPW = 4;

  logic           start;
  logic [OPW-1:0] Op;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic [W-1:0]   HI;
  logic [W-1:0]   LO;

  modport master (
    output start, Op, A, B,
    input  busy, done, div_by_zero, HI, LO
  );

  modport slave (
    input  start, Op, A, B,
    output busy, done, div_by_zero, HI, LO
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Sequential signed 32x32 unit: radix-2 Booth multiply or restoring divide.
// Each operation takes one bit per cycle over a fixed 32-cycle RUN phase.
module muldiv_sequencer (
  input  logic                  clock,
  input  logic                  clear,
  muldiv_sequencer_if.slave     bus
);
  localparam int unsigned W   = 32;
  localparam int unsigned CW  = 5;
  localparam int unsigned HW  = W + 1;
  localparam int unsigned AW  = 2 * W + 1;
  localparam logic [3:0]  OP_MUL = 4'b0011;
  localparam logic [3:0]  OP_DIV = 4'b0010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [CW-1:0]  r_count;
  logic [AW-1:0]  r_acc;
  logic           r_qm1;
  logic [HW-1:0]  r_mcand;
  logic           r_is_mul;
  logic           r_q_neg;
  logic           r_r_neg;
  logic           r_busy;
  logic           r_done;
  logic           r_dbz;
  logic [W-1:0]   r_hi;
  logic [W-1:0]   r_lo;

  logic           w_op_ok;
  logic           w_accept;
  logic           w_div_zero;
  logic           w_last;
  logic [W-1:0]   w_abs_a;
  logic [W-1:0]   w_abs_b;
  logic [HW-1:0]  w_hi_sum;
  logic [HW-1:0]  w_div_shift;
  logic [HW-1:0]  w_div_trial;
  logic [AW-1:0]  w_acc_step;
  logic           w_qm1_step;
  logic [W-1:0]   w_q_mag;
  logic [W-1:0]   w_r_mag;
  logic [W-1:0]   w_res_hi;
  logic [W-1:0]   w_res_lo;
  logic           w_unused_top;

  // Request qualification
  assign w_op_ok    = (bus.Op == OP_MUL) || (bus.Op == OP_DIV);
  assign w_accept   = (r_state == S_IDLE) && bus.start && w_op_ok;
  assign w_div_zero = (bus.Op == OP_DIV) && (bus.B == '0);
  assign w_last     = (r_count == CW'(W - 1));
  assign w_abs_a    = bus.A[W-1] ? (~bus.A + W'(1)) : bus.A;
  assign w_abs_b    = bus.B[W-1] ? (~bus.B + W'(1)) : bus.B;

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = w_div_zero ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // One iteration: Booth add/sub + arithmetic shift, or one restoring-divide step.
  // The divide shares the accumulator: remainder in [64:32], quotient shifts in at [31:0].
  always_comb begin
    w_hi_sum    = r_acc[AW-1:W];
    w_div_shift = '0;
    w_div_trial = '0;
    w_acc_step  = r_acc;
    w_qm1_step  = r_qm1;
    if (r_is_mul) begin
      case ({r_acc[0], r_qm1})
        2'b10:   w_hi_sum = r_acc[AW-1:W] - r_mcand;
        2'b01:   w_hi_sum = r_acc[AW-1:W] + r_mcand;
        default: w_hi_sum = r_acc[AW-1:W];
      endcase
      w_acc_step = {w_hi_sum[HW-1], w_hi_sum, r_acc[W-1:1]};
      w_qm1_step = r_acc[0];
    end else begin
      w_div_shift = {r_acc[2*W-1:W], r_acc[W-1]};
      w_div_trial = w_div_shift - r_mcand;
      if (!w_div_trial[HW-1]) begin
        w_acc_step = {w_div_trial, r_acc[W-2:0], 1'b1};
      end else begin
        w_acc_step = {w_div_shift, r_acc[W-2:0], 1'b0};
      end
    end
  end

  // Final result formatting; divide applies truncating-division signs to the magnitudes
  assign w_q_mag      = w_acc_step[W-1:0];
  assign w_r_mag      = w_acc_step[2*W-1:W];
  assign w_unused_top = w_acc_step[AW-1];
  always_comb begin
    w_res_hi = w_acc_step[2*W-1:W];
    w_res_lo = w_acc_step[W-1:0];
    if (!r_is_mul) begin
      w_res_lo = r_q_neg ? (~w_q_mag + W'(1)) : w_q_mag;
      w_res_hi = r_r_neg ? (~w_r_mag + W'(1)) : w_r_mag;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_acc    <= '0;
      r_qm1    <= 1'b0;
      r_mcand  <= '0;
      r_is_mul <= 1'b0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= (w_state_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_count  <= '0;
            r_dbz    <= w_div_zero;
            r_is_mul <= (bus.Op == OP_MUL);
            r_q_neg  <= bus.A[W-1] ^ bus.B[W-1];
            r_r_neg  <= bus.A[W-1];
            r_qm1    <= 1'b0;
            if (bus.Op == OP_MUL) begin
              r_acc   <= {HW'(0), bus.B};
              r_mcand <= {bus.A[W-1], bus.A};
            end else begin
              r_acc   <= {HW'(0), w_abs_a};
              r_mcand <= {1'b0, w_abs_b};
            end
            if (w_div_zero) begin
              r_hi <= bus.A;
              r_lo <= '1;
            end
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_step;
          r_qm1   <= w_qm1_step;
          r_count <= r_count + CW'(1);
          if (w_last) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.HI          = r_hi;
  assign bus.LO          = r_lo;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: the driver queues expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0010;
  localparam logic [3:0] OP_BAD = 4'b0100;

  logic clock = 1'b0;
  logic clear;

  muldiv_sequencer_if bus();

  muldiv_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          blen;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   blen = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: busy-run length tracking and scoreboard compare on done
  always @(negedge clock) begin : monitor
    exp_t e;
    if (bus.busy === 1'b1) blen = blen + 1;
    else blen = 0;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1 with HI=0x%08h LO=0x%08h, expected no done", bus.HI, bus.LO);
      end else begin
        e = sb.pop_front();
        check32({e.name, "_hi"}, bus.HI, e.hi);
        check32({e.name, "_lo"}, bus.LO, e.lo);
        check32({e.name, "_dbz"}, 32'(bus.div_by_zero), 32'(e.dbz));
        check32({e.name, "_busy_cycles"}, 32'(blen), 32'(e.blen));
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                       input string name);
    exp_t e;
    @(negedge clock);
    bus.start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    e.hi   = ehi;
    e.lo   = elo;
    e.dbz  = edbz;
    e.blen = edbz ? 1 : 33;
    e.name = name;
    sb.push_back(e);
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.busy === 1'b0) break;
    end
    check32({name, "_idle_timeout"}, 32'(i >= 100), 32'd0);
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1) break;
    end
    check32({name, "_done_timeout"}, 32'(i >= 100), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    clear     = 1'b1;
    bus.start = 1'b0;
    bus.Op    = 4'd0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    repeat (3) @(negedge clock);
    check32("rst_busy", 32'(bus.busy), 32'd0);
    check32("rst_done", 32'(bus.done), 32'd0);
    check32("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    check32("rst_hi", bus.HI, 32'd0);
    check32("rst_lo", bus.LO, 32'd0);
    clear = 1'b0;

    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mul_7_m3");
    wait_idle("mul_7_m3");
    issue(OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, "mul_min_min");
    wait_idle("mul_min_min");
    issue(OP_DIV, 32'hFFFF_FFEF, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, "div_m17_5");
    wait_idle("div_m17_5");
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_min_m1");
    wait_idle("div_min_m1");
    issue(OP_DIV, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, "div_by_zero");
    wait_idle("div_by_zero");

    // Mid-RUN start pulse and input changes must be ignored
    issue(OP_MUL, 32'd100, 32'd200, 32'd0, 32'h0000_4E20, 1'b0, "mul_ignore");
    repeat (9) @(negedge clock);
    bus.start = 1'b1;
    bus.Op    = OP_DIV;
    bus.A     = 32'd5;
    bus.B     = 32'd0;
    @(negedge clock);
    bus.start = 1'b0;
    bus.A     = 32'hDEAD_BEEF;
    bus.B     = 32'h1234_5678;
    wait_idle("mul_ignore");

    // Unsupported opcode in IDLE is ignored
    @(negedge clock);
    bus.start = 1'b1;
    bus.Op    = OP_BAD;
    bus.A     = 32'd1;
    bus.B     = 32'd1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (2) @(negedge clock);
    check32("badop_busy", 32'(bus.busy), 32'd0);
    check32("badop_hi", bus.HI, 32'd0);
    check32("badop_lo", bus.LO, 32'h0000_4E20);

    issue(OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "div_100_7");
    wait_idle("div_100_7");
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, "div_7_m2");
    wait_idle("div_7_m2");

    // Abort at RUN count 15
    issue(OP_MUL, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0, "mul_aborted");
    repeat (15) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check32("abort_queued", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) void'(sb.pop_back());
    check32("abort_busy", 32'(bus.busy), 32'd0);
    check32("abort_done", 32'(bus.done), 32'd0);
    check32("abort_hi", bus.HI, 32'd0);
    check32("abort_lo", bus.LO, 32'd0);
    issue(OP_MUL, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, "mul_3_4");
    wait_idle("mul_3_4");

    // Back-to-back: second start in the IDLE cycle right after DONE
    issue(OP_MUL, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, "b2b_first");
    wait_done("b2b_first");
    issue(OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, "b2b_second");
    wait_idle("b2b_second");

    repeat (3) @(negedge clock);
    check32("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
